// File: rtl/gf2m_pkg.sv
// Shared constants, state encoding and reduction helpers for the GF(2^163) digit-serial multiplier.
// f(x) = x^163 + x^7 + x^6 + x^3 + 1.
package gf2m_pkg;

   localparam int M        = 163;
   localparam int D        = 4;
   localparam int N_DIGITS = (M + D - 1) / D;
   localparam int PAD_W    = N_DIGITS * D;
   localparam int CNT_W    = $clog2(N_DIGITS);

   localparam logic [7:0] F_TAIL = 8'b1100_1001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Folds bits M..M+D-1 down with x^163 = x^7+x^6+x^3+1; one pass suffices since folds land at bit 10 or below.
   function automatic logic [M-1:0] gf_fold(input logic [M+D-1:0] v);
      logic [M+D-1:0] r;
      r = v;
      for (int i = M + D - 1; i >= M; i--) begin
         r[i-M +: 8] = r[i-M +: 8] ^ (r[i] ? F_TAIL : 8'h00);
      end
      return r[M-1:0];
   endfunction

   function automatic logic [CNT_W-1:0] top_digit(input logic [PAD_W-1:0] bp);
      logic [CNT_W-1:0] h;
      h = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         h = (|bp[i*D +: D]) ? CNT_W'(i) : h;
      end
      return h;
   endfunction

endpackage

// File: rtl/gf2m_digit_step.sv
// One digit step of the multiplier: next = (acc*x^4 mod f) ^ (a*digit mod f).
// Purely combinational.
module gf2m_digit_step
   import gf2m_pkg::*;
(
   input  logic [M-1:0] acc_i,
   input  logic [M-1:0] a_i,
   input  logic [D-1:0] digit_i,
   output logic [M-1:0] acc_o
);

   logic [M+D-1:0] shifted_s;
   logic [M+D-1:0] pp_s;

   // Shifted accumulator and carry-free partial product, each reduced before the final combine.
   always_comb begin
      shifted_s = {acc_i, {D{1'b0}}};
      pp_s      = '0;
      for (int j = 0; j < D; j++) begin
         pp_s = pp_s ^ (digit_i[j] ? ({{D{1'b0}}, a_i} << j) : {(M+D){1'b0}});
      end
      acc_o = gf_fold(shifted_s) ^ gf_fold(pp_s);
   end

endmodule

// File: rtl/gf2m_digit_mul.sv
// Digit-serial GF(2^163) multiplier controller: scans b MSB-first, 4 bits per clock.
// Optional GF_MUL_ZERO_SKIP_EN starts the scan at the highest nonzero digit of b.
module gf2m_digit_mul
   import gf2m_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [M-1:0] a_i,
   input  logic [M-1:0] b_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [M-1:0] c_o,
   output logic         busy_o
);

   state_e             state_q;
   logic [M-1:0]       a_q;
   logic [M-1:0]       b_q;
   logic [M-1:0]       acc_q;
   logic [M-1:0]       acc_d;
   logic [M-1:0]       c_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_load_s;
   logic [PAD_W-1:0]   b_pad_s;
   logic [D-1:0]       digit_s;
   logic               out_valid_q;
   logic               busy_q;

   assign b_pad_s = {{(PAD_W-M){1'b0}}, b_q};
   assign digit_s = b_pad_s[int'(cnt_q)*D +: D];

`ifdef GF_MUL_ZERO_SKIP_EN
   assign cnt_load_s = top_digit({{(PAD_W-M){1'b0}}, b_i});
`else
   assign cnt_load_s = CNT_W'(N_DIGITS - 1);
`endif

   gf2m_digit_step u_step (
      .acc_i   (acc_q),
      .a_i     (a_q),
      .digit_i (digit_s),
      .acc_o   (acc_d)
   );

   // Control FSM with operand, accumulator, counter and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         c_q         <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid_i) begin
                  a_q     <= a_i;
                  b_q     <= b_i;
                  acc_q   <= '0;
                  cnt_q   <= cnt_load_s;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               acc_q <= acc_d;
               if (cnt_q == '0) begin
                  c_q         <= acc_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end else begin
                  state_q <= DONE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = out_valid_q;
   assign busy_o      = busy_q;
   assign c_o         = c_q;

endmodule

// File: tb/tb_gf2m_digit_mul.sv
// Directed and random checks of gf2m_digit_mul against a bit-serial reference multiplier.
module tb_gf2m_digit_mul;
   import gf2m_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [M-1:0] a;
   logic [M-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [M-1:0] c;
   logic         busy;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   gf2m_digit_mul dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (a),
      .b_i         (b),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .c_o         (c),
      .busy_o      (busy)
   );

   typedef struct {
      logic [M-1:0] a;
      logic [M-1:0] b;
      logic [M-1:0] c;
   } vec_t;

   vec_t vt [9];

   task automatic chk(input string nm, input logic [M-1:0] act, input logic [M-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [M-1:0] bitv(input int k);
      logic [M-1:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   function automatic logic [M-1:0] rand_fe();
      logic [191:0] w;
      w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return w[M-1:0];
   endfunction

   // Shift-and-add with one-bit reduction per step.
   function automatic logic [M-1:0] ref_mul(input logic [M-1:0] x, input logic [M-1:0] y);
      logic [M-1:0] r;
      logic [M-1:0] poly;
      logic         msb;
      r = '0;
      poly = '0;
      poly[7] = 1'b1; poly[6] = 1'b1; poly[3] = 1'b1; poly[0] = 1'b1;
      for (int i = M - 1; i >= 0; i--) begin
         msb = r[M-1];
         r = {r[M-2:0], 1'b0};
         if (msb) r = r ^ poly;
         if (y[i]) r = r ^ x;
      end
      return r;
   endfunction

   function automatic int exp_lat(input logic [M-1:0] y);
`ifdef GF_MUL_ZERO_SKIP_EN
      logic [PAD_W-1:0] p;
      int h;
      p = {{(PAD_W-M){1'b0}}, y};
      h = 0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (p[4*i +: 4] != 4'h0) h = i;
      end
      return h + 1;
`else
      return 41 + (y == y ? 0 : 1);
`endif
   endfunction

   task automatic issue(input logic [M-1:0] xa, input logic [M-1:0] xb);
      a = xa;
      b = xb;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = ~xa;
      b = ~xb;
   endtask

   task automatic wait_done(output int lat, output bit busy_ok);
      lat = 0;
      busy_ok = 1'b1;
      while (out_valid !== 1'b1 && lat < 100) begin
         busy_ok = busy_ok & (busy === 1'b1);
         @(posedge clk); #1;
         lat++;
      end
      busy_ok = busy_ok & (busy === 1'b1);
   endtask

   task automatic release_out(input int stall, output bit ok);
      logic [M-1:0] c0;
      c0 = c;
      ok = 1'b1;
      for (int k = 0; k < stall; k++) begin
         @(posedge clk); #1;
         ok = ok & (out_valid === 1'b1) & (c === c0) & (in_ready === 1'b0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      ok = ok & (out_valid === 1'b0) & (in_ready === 1'b1) & (c === c0);
   endtask

   task automatic run_op(input logic [M-1:0] xa, input logic [M-1:0] xb, input int stall,
                         output logic [M-1:0] res, output int lat, output bit busy_ok, output bit hs_ok);
      issue(xa, xb);
      wait_done(lat, busy_ok);
      res = c;
      release_out(stall, hs_ok);
   endtask

   initial begin
      logic [M-1:0] res;
      logic [M-1:0] ra;
      logic [M-1:0] rb;
      logic [M-1:0] c_hold;
      int           lat;
      bit           busy_ok;
      bit           hs_ok;
      int           n_res;

      vt[0] = '{a: M'(1),     b: M'(1),       c: M'(1)};
      vt[1] = '{a: bitv(162), b: M'(2),       c: M'(12'h0C9)};
      vt[2] = '{a: rand_fe(), b: '0,          c: '0};
      vt[3] = '{a: M'(3),     b: M'(5),       c: M'(4'hF)};
      vt[4] = '{a: M'(3),     b: M'(3),       c: M'(4'h5)};
      vt[5] = '{a: bitv(160), b: M'(8'h10),   c: M'(12'h192)};
      vt[6] = '{a: bitv(162), b: M'(4'hF),    c: bitv(162) | M'(12'h27F)};
      vt[7] = '{a: M'(5),     b: bitv(100),   c: bitv(100) | bitv(102)};
      vt[8] = '{a: M'(1),     b: M'(8'h10),   c: M'(8'h10)};

      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", M'(in_ready), M'(1));
      chk("reset_out_valid", M'(out_valid), M'(0));
      chk("reset_busy", M'(busy), M'(0));
      chk("reset_c", c, '0);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_op(vt[i].a, vt[i].b, i % 3, res, lat, busy_ok, hs_ok);
         chk($sformatf("vec%0d_c", i), res, vt[i].c);
         chk($sformatf("vec%0d_latency", i), M'(lat), M'(exp_lat(vt[i].b)));
         chk($sformatf("vec%0d_busy", i), M'(busy_ok), M'(1));
         chk($sformatf("vec%0d_handshake", i), M'(hs_ok), M'(1));
      end

      // Hold in DONE with out_ready low while in_valid toggles.
      issue(bitv(162), M'(2));
      wait_done(lat, busy_ok);
      c_hold = c;
      chk("hold_c_first", c_hold, M'(12'h0C9));
      for (int k = 0; k < 10; k++) begin
         in_valid = ~k[0];
         a = rand_fe();
         b = rand_fe();
         @(posedge clk); #1;
         chk("hold_c", c, M'(12'h0C9));
         chk("hold_out_valid", M'(out_valid), M'(1));
         chk("hold_in_ready", M'(in_ready), M'(0));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_in_ready", M'(in_ready), M'(1));
      chk("release_out_valid", M'(out_valid), M'(0));
      chk("release_c_kept", c, M'(12'h0C9));
      run_op(M'(3), M'(5), 0, res, lat, busy_ok, hs_ok);
      chk("after_hold_c", res, M'(4'hF));
      chk("after_hold_latency", M'(lat), M'(exp_lat(M'(5))));

      // Synchronous reset in the middle of RUN.
      issue(rand_fe() | bitv(162), rand_fe() | bitv(161));
      repeat (20) begin
         @(posedge clk); #1;
      end
      chk("midrun_busy", M'(busy), M'(1));
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("midrun_rst_in_ready", M'(in_ready), M'(1));
      chk("midrun_rst_out_valid", M'(out_valid), M'(0));
      chk("midrun_rst_busy", M'(busy), M'(0));
      chk("midrun_rst_c", c, '0);
      run_op(M'(3), M'(5), 1, res, lat, busy_ok, hs_ok);
      chk("after_rst_c", res, M'(4'hF));
      chk("after_rst_handshake", M'(hs_ok), M'(1));

      // Back-to-back random operands with random consumer stalls.
      n_res = 0;
      for (int i = 0; i < 1000; i++) begin
         ra = rand_fe();
         rb = rand_fe();
         if (i % 4 == 1) rb = rb >> $urandom_range(0, 162);
         if (i % 16 == 2) rb = '0;
         if (i % 16 == 6) ra = '0;
         run_op(ra, rb, int'($urandom_range(0, 2)), res, lat, busy_ok, hs_ok);
         if (lat < 100) n_res++;
         chk($sformatf("rand%0d_c", i), res, ref_mul(ra, rb));
         chk($sformatf("rand%0d_latency", i), M'(lat), M'(exp_lat(rb)));
         chk($sformatf("rand%0d_handshake", i), M'(hs_ok & busy_ok), M'(1));
      end
      chk("rand_result_count", M'(n_res), M'(1000));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
